// File: rtl/sequential_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, {remainder, quotient} output.
// Optional macro SEQUENTIAL_DIVIDER_SIGNED_EN selects two's-complement operands with sign fix-up.
module sequential_divider #(
    parameter int p_data_width = 8
) (
    input  logic                        i_w_clk,
    input  logic                        i_w_reset,
    input  logic [p_data_width-1:0]     i_w_a,
    input  logic [p_data_width-1:0]     i_w_b,
    input  logic                        i_w_write,
    input  logic                        i_w_divide,
    input  logic                        i_w_display,
    output logic [2*p_data_width-1:0]   o_w_out,
    output logic                        o_w_busy,
    output logic                        o_w_done,
    output logic                        o_w_div_by_zero
);

    localparam int W  = p_data_width;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state, w_state_nxt;
    logic [W-1:0]   r_a, w_a_nxt;
    logic [W-1:0]   r_b, w_b_nxt;
    logic [W-1:0]   r_rem, w_rem_nxt;
    logic [W-1:0]   r_quo, w_quo_nxt;
    logic [CW-1:0]  r_cnt, w_cnt_nxt;
    logic           r_done, w_done_nxt;
    logic           r_dbz, w_dbz_nxt;

    logic [W-1:0]   w_a_mag;
    logic [W-1:0]   w_b_mag;
    logic [W:0]     w_shift;
    logic [W+1:0]   w_diff;
    logic           w_ge;
    logic [W-1:0]   w_rem_step;
    logic [W-1:0]   w_quo_step;
    logic [W-1:0]   w_rem_fix;
    logic [W-1:0]   w_quo_fix;

`ifdef SEQUENTIAL_DIVIDER_SIGNED_EN
    logic           w_a_neg;
    logic           w_b_neg;

    // Magnitudes feed the unsigned core; signs restored on the final step
    always_comb begin
        w_a_neg   = r_a[W-1];
        w_b_neg   = r_b[W-1];
        w_a_mag   = w_a_neg ? ({W{1'b0}} - r_a) : r_a;
        w_b_mag   = w_b_neg ? ({W{1'b0}} - r_b) : r_b;
        w_quo_fix = (w_a_neg ^ w_b_neg) ? ({W{1'b0}} - w_quo_step) : w_quo_step;
        w_rem_fix = w_a_neg ? ({W{1'b0}} - w_rem_step) : w_rem_step;
    end
`else
    // Unsigned build: operands used directly, no fix-up
    always_comb begin
        w_a_mag   = r_a;
        w_b_mag   = r_b;
        w_quo_fix = w_quo_step;
        w_rem_fix = w_rem_step;
    end
`endif

    // One restoring step; the extra top bit of w_diff is the borrow
    always_comb begin
        w_shift    = {r_rem, r_quo[W-1]};
        w_diff     = {1'b0, w_shift} - {2'b00, w_b_mag};
        w_ge       = ~w_diff[W+1];
        w_rem_step = w_ge ? w_diff[W-1:0] : w_shift[W-1:0];
        w_quo_step = {r_quo[W-2:0], w_ge};
    end

    // Next-state and datapath control
    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_rem_nxt   = r_rem;
        w_quo_nxt   = r_quo;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = r_done;
        w_dbz_nxt   = r_dbz;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_w_write) begin
                    w_a_nxt     = i_w_a;
                    w_b_nxt     = i_w_b;
                    w_done_nxt  = 1'b0;
                    w_dbz_nxt   = 1'b0;
                    w_state_nxt = S_IDLE;
                end else if (i_w_divide) begin
                    if (r_b == {W{1'b0}}) begin
                        w_quo_nxt   = {W{1'b1}};
                        w_rem_nxt   = r_a;
                        w_dbz_nxt   = 1'b1;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_rem_nxt   = {W{1'b0}};
                        w_quo_nxt   = w_a_mag;
                        w_cnt_nxt   = CW'(W);
                        w_dbz_nxt   = 1'b0;
                        w_done_nxt  = 1'b0;
                        w_state_nxt = S_BUSY;
                    end
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_BUSY: begin
                w_cnt_nxt = r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    w_rem_nxt   = w_rem_fix;
                    w_quo_nxt   = w_quo_fix;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_rem_nxt   = w_rem_step;
                    w_quo_nxt   = w_quo_step;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge i_w_clk or posedge i_w_reset) begin
        if (i_w_reset) begin
            r_state <= S_IDLE;
            r_a     <= {W{1'b0}};
            r_b     <= {W{1'b0}};
            r_rem   <= {W{1'b0}};
            r_quo   <= {W{1'b0}};
            r_cnt   <= {CW{1'b0}};
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_rem   <= w_rem_nxt;
            r_quo   <= w_quo_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
            r_dbz   <= w_dbz_nxt;
        end
    end

    // Output drive from registered state
    always_comb begin
        o_w_out         = i_w_display ? {r_rem, r_quo} : {(2*W){1'b0}};
        o_w_busy        = (r_state == S_BUSY);
        o_w_done        = r_done;
        o_w_div_by_zero = r_dbz;
    end

endmodule

// File: tb/tb_sequential_divider.sv
// Scoreboard bench for sequential_divider (W=8); expected {dbz, R, Q} queued on each divide.
module tb_sequential_divider;

    localparam int W = 8;

    logic           clk;
    logic           rst;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           write;
    logic           divide;
    logic           display;
    logic [2*W-1:0] out;
    logic           busy;
    logic           done;
    logic           dbz;

    int             n_checks;
    int             n_errors;
    logic [2*W:0]   sb_q[$];
    logic [2*W:0]   exp_v;
    logic [W-1:0]   cur_a;
    logic [W-1:0]   cur_b;
    int             bc;
    bit             to;

    sequential_divider #(.p_data_width(W)) dut (
        .i_w_clk         (clk),
        .i_w_reset       (rst),
        .i_w_a           (a),
        .i_w_b           (b),
        .i_w_write       (write),
        .i_w_divide      (divide),
        .i_w_display     (display),
        .o_w_out         (out),
        .o_w_busy        (busy),
        .o_w_done        (done),
        .o_w_div_by_zero (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2*W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb);
        int q;
        int r;
        if (mb == 8'd0) return {1'b1, ma, 8'hFF};
`ifdef SEQUENTIAL_DIVIDER_SIGNED_EN
        begin
            int ia;
            int ib;
            ia = $signed(ma);
            ib = $signed(mb);
            q  = ia / ib;
            r  = ia % ib;
        end
`else
        q = int'(ma) / int'(mb);
        r = int'(ma) % int'(mb);
`endif
        return {1'b0, r[W-1:0], q[W-1:0]};
    endfunction

    task automatic do_write(input logic [W-1:0] av, input logic [W-1:0] bv);
        a = av; b = bv; write = 1'b1;
        @(posedge clk); #1;
        write = 1'b0;
        cur_a = av; cur_b = bv;
    endtask

    task automatic do_divide();
        divide = 1'b1;
        sb_q.push_back(model(cur_a, cur_b));
        @(posedge clk); #1;
        divide = 1'b0;
    endtask

    task automatic wait_done(output int busy_cyc, output bit timed_out);
        busy_cyc  = 0;
        timed_out = 1'b1;
        for (int i = 0; i < 4*W + 8; i++) begin
            if (done) begin
                timed_out = 1'b0;
                return;
            end
            if (busy) busy_cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if ({out, busy, done, dbz} !== {(2*W+3){1'b0}}) begin
            n_errors++;
            $display("FAIL reset_outputs: got out=%0d busy=%0b done=%0b dbz=%0b, expected all 0", out, busy, done, dbz);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({out, busy, done, dbz} !== {(2*W+3){1'b0}}) begin
            n_errors++;
            $display("FAIL reset_idle: got out=%0d busy=%0b done=%0b, expected 0", out, busy, done);
        end
    endtask

    task automatic test_basic();
        do_write(8'd100, 8'd7);
        do_divide();
        wait_done(bc, to);
        exp_v = sb_q.pop_front();
        n_checks++;
        if (to) begin n_errors++; $display("FAIL basic_timeout: done not seen"); end
        n_checks++;
        if (bc !== W) begin n_errors++; $display("FAIL basic_busy_cycles: got %0d expected %0d", bc, W); end
        n_checks++;
        if ({dbz, out} !== exp_v) begin n_errors++; $display("FAIL basic_sb: got %h expected %h", {dbz, out}, exp_v); end
        n_checks++;
        if (out !== 16'd526) begin n_errors++; $display("FAIL basic_const: got %0d expected 526", out); end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b1 || out !== 16'd526) begin
            n_errors++; $display("FAIL done_hold: got done=%0b out=%0d expected 1/526", done, out);
        end
        display = 1'b0;
        #1;
        n_checks++;
        if (out !== 16'd0 || done !== 1'b1) begin
            n_errors++; $display("FAIL display_off: got out=%0d done=%0b expected 0/1", out, done);
        end
        display = 1'b1;
    endtask

    task automatic test_div_zero();
        do_write(8'd5, 8'd0);
        n_checks++;
        if (done !== 1'b0) begin n_errors++; $display("FAIL write_clears_done: got %0b expected 0", done); end
        do_divide();
        wait_done(bc, to);
        exp_v = sb_q.pop_front();
        n_checks++;
        if (to || bc !== 0) begin n_errors++; $display("FAIL dz_latency: got busy=%0d timeout=%0b expected 0/0", bc, to); end
        n_checks++;
        if ({dbz, out} !== {1'b1, 16'd1535}) begin
            n_errors++; $display("FAIL dz_result: got dbz=%0b out=%0d expected 1/1535", dbz, out);
        end
        n_checks++;
        if ({dbz, out} !== exp_v) begin n_errors++; $display("FAIL dz_sb: got %h expected %h", {dbz, out}, exp_v); end
    endtask

    task automatic test_small();
        logic [W-1:0] av [3];
        logic [W-1:0] bv [3];
        logic [15:0]  kv [3];
        av = '{8'd3, 8'd255, 8'd255};
        bv = '{8'd10, 8'd1, 8'd1};
        kv = '{16'd768, 16'd255, 16'd255};
        for (int i = 0; i < 3; i++) begin
            if (i < 2) do_write(av[i], bv[i]);
            do_divide();
            wait_done(bc, to);
            exp_v = sb_q.pop_front();
            n_checks++;
            if (to || {dbz, out} !== exp_v || out !== kv[i]) begin
                n_errors++;
                $display("FAIL small_%0d: got dbz=%0b out=%0d expected %h (const %0d)", i, dbz, out, exp_v, kv[i]);
            end
        end
    endtask

    task automatic test_busy_ignore();
        do_write(8'd200, 8'd9);
        do_divide();
        repeat (2) @(posedge clk);
        #1;
        a = 8'd1; b = 8'd1; write = 1'b1; divide = 1'b1;
        @(posedge clk); #1;
        write = 1'b0; divide = 1'b0;
        wait_done(bc, to);
        exp_v = sb_q.pop_front();
        n_checks++;
        if (to || {dbz, out} !== exp_v) begin
            n_errors++; $display("FAIL busy_ignore: got %h expected %h", {dbz, out}, exp_v);
        end
`ifndef SEQUENTIAL_DIVIDER_SIGNED_EN
        n_checks++;
        if (out !== 16'd534) begin n_errors++; $display("FAIL busy_ignore_const: got %0d expected 534", out); end
`endif
        a = 8'd50; b = 8'd5; write = 1'b1; divide = 1'b1;
        @(posedge clk); #1;
        write = 1'b0; divide = 1'b0;
        cur_a = 8'd50; cur_b = 8'd5;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_errors++; $display("FAIL write_wins: got busy=%0b done=%0b expected 0/0", busy, done);
        end
        do_divide();
        wait_done(bc, to);
        exp_v = sb_q.pop_front();
        n_checks++;
        if (to || {dbz, out} !== exp_v || out !== 16'd10) begin
            n_errors++; $display("FAIL write_wins_result: got %h expected %h", {dbz, out}, exp_v);
        end
    endtask

    task automatic test_reset_abort();
        do_write(8'd200, 8'd9);
        do_divide();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({out, busy, done, dbz} !== {(2*W+3){1'b0}}) begin
            n_errors++; $display("FAIL abort_outputs: got out=%0d busy=%0b done=%0b dbz=%0b expected 0", out, busy, done, dbz);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        void'(sb_q.pop_front());
        cur_a = 8'd0; cur_b = 8'd0;
        do_divide();
        wait_done(bc, to);
        exp_v = sb_q.pop_front();
        n_checks++;
        if (to || {dbz, out} !== exp_v || dbz !== 1'b1) begin
            n_errors++; $display("FAIL abort_then_dz: got %h expected %h", {dbz, out}, exp_v);
        end
    endtask

`ifdef SEQUENTIAL_DIVIDER_SIGNED_EN
    task automatic test_signed();
        do_write(8'h9C, 8'd7);
        do_divide();
        wait_done(bc, to);
        exp_v = sb_q.pop_front();
        n_checks++;
        if (to || out !== 16'hFEF2 || {dbz, out} !== exp_v) begin
            n_errors++; $display("FAIL signed_neg: got %h expected FEF2", out);
        end
        do_write(8'h80, 8'hFF);
        do_divide();
        wait_done(bc, to);
        exp_v = sb_q.pop_front();
        n_checks++;
        if (to || out !== 16'h0080 || dbz !== 1'b0) begin
            n_errors++; $display("FAIL signed_overflow: got dbz=%0b out=%h expected 0/0080", dbz, out);
        end
    endtask
`endif

    task automatic test_back_to_back();
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        for (int i = 0; i < 12; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = ($urandom_range(0, 4) == 0) ? 8'd0 : W'($urandom_range(1, 255));
            do_write(ra, rb);
            for (int k = 0; k < 2; k++) begin
                do_divide();
                wait_done(bc, to);
                exp_v = sb_q.pop_front();
                n_checks++;
                if (to || {dbz, out} !== exp_v || bc !== ((rb == 8'd0) ? 0 : W)) begin
                    n_errors++;
                    $display("FAIL b2b_%0d_%0d: a=%0d b=%0d got %h busy=%0d expected %h", i, k, ra, rb, {dbz, out}, bc, exp_v);
                end
            end
        end
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        rst = 1'b1; a = '0; b = '0; write = 1'b0; divide = 1'b0; display = 1'b1;
        cur_a = '0; cur_b = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_div_zero();
        test_small();
        test_busy_ignore();
        test_reset_abort();
`ifdef SEQUENTIAL_DIVIDER_SIGNED_EN
        test_signed();
`endif
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sequential_divider.md
Name: sequential_divider

Overview:
Multi-cycle unsigned restoring divider. It performs the inverse operation of the team's sequential multiplier and reuses the same write/operate/display control style.
- Operands are latched with a write strobe.
- Division is started with a divide strobe and produces one quotient bit per clock.
- The {remainder, quotient} result is presented on a 2*p_data_width output when display is enabled.
- Used in the memory/sequential lab drills alongside the multiplier.

Parameters:
p_data_width, 8, operand width W; quotient and remainder are each W bits.

Ports:
i_w_clk  input  1  system clock; all state changes on the rising edge.
i_w_reset  input  1  asynchronous, active-high reset.
i_w_a  input  W  dividend, sampled on write.
i_w_b  input  W  divisor, sampled on write.
i_w_write  input  1  load i_w_a/i_w_b into the operand registers.
i_w_divide  input  1  start a division on the latched operands.
i_w_display  input  1  1: drive the result on o_w_out; 0: o_w_out = 0.
o_w_out  output  2W  {remainder[W-1:0], quotient[W-1:0]} when displayed.
o_w_busy  output  1  high while iterating.
o_w_done  output  1  result valid; held until the next write or divide.
o_w_div_by_zero  output  1  last division had divisor 0; valid with o_w_done.

Behaviour:
- Reset (asynchronous, active-high):
  - State IDLE.
  - Operand, partial-remainder, quotient and counter registers cleared.
  - o_w_out=0, o_w_busy=0, o_w_done=0, o_w_div_by_zero=0.
  - Reset asserted mid-division aborts immediately; no partial result is retained.
- FSM states: IDLE, BUSY, DONE.
  - IDLE/DONE, write=1: latch A=i_w_a, B=i_w_b; clear done and div_by_zero; go to (or stay in) IDLE.
  - IDLE/DONE, write=0, divide=1, B!=0: R=0, Q=A, counter=W; go to BUSY. This is the start edge.
  - IDLE/DONE, write=0, divide=1, B==0: Q=all ones, R=A, div_by_zero=1; go to DONE on that edge (1-cycle result).
  - write and divide high together: write wins; divide is ignored that cycle.
  - BUSY: each edge performs one restoring step and decrements the counter.
    - Step: T={R[W-1:0],Q[W-1]} minus B, computed W+1 bits wide.
    - T non-negative: R=T[W-1:0] and shift 1 into Q.
    - Otherwise: R={R[W-2:0],Q[W-1]} and shift 0 into Q.
    - On the step where counter==1, go to DONE.
  - BUSY: write and divide are ignored; operand registers are untouched.
  - DONE: results hold indefinitely. A divide re-runs on the same latched operands.
- Latency: with the start at edge 0, o_w_done rises after edge W and o_w_busy falls after edge W.
  - o_w_busy=1 for exactly W clock cycles.
- Outputs:
  - o_w_out is combinational from registered R/Q gated by i_w_display.
  - During BUSY with display=1, intermediate values are visible; they are unspecified for checking.
  - o_w_done and o_w_div_by_zero are registered.
- Arithmetic: unsigned; the invariant A == Q*B + R with R < B holds at DONE for B!=0.
- Width: internal remainder is W+1 bits for the compare/subtract only.

Optional Feature:
SEQUENTIAL_DIVIDER_SIGNED_EN
- Defined:
  - Operands are two's complement.
  - Magnitudes are divided by the same unsigned core.
  - The quotient is negated when the operand signs differ, truncating toward zero.
  - The remainder takes the dividend's sign.
  - Most-negative / -1 gives quotient = most-negative (wraps) and remainder 0, with no flag.
  - Divide by zero gives Q = all ones, R = A, flag set.
  - Sign fix-up occurs on the DONE transition edge, so latency is unchanged.
- Undefined: purely unsigned behaviour as above.

Test Plan (W=8):
1. Reset, write A=100 B=7, divide, display=1 -> busy for 8 cycles, then done=1, o_w_out=(2<<8)|14=526, div_by_zero=0.
2. Write A=5 B=0, divide -> next edge done=1, div_by_zero=1, o_w_out=(5<<8)|255=1535; busy never asserted.
3. Write A=3 B=10, divide -> quotient 0, remainder 3 (o_w_out=768). Then write A=255 B=1, divide -> o_w_out=255. Display=0 -> o_w_out=0 while done stays 1.
4. Start 200/9, assert write A=1 B=1 and divide at cycle 3 of BUSY -> both ignored; result q=22 r=2 (o_w_out=534). Write and divide in the same IDLE cycle -> operands load, no start.
5. Start 200/9, pulse reset at cycle 4 -> all outputs 0 immediately, state IDLE. A following divide on cleared operands (B=0) -> div_by_zero=1.
6. With SEQUENTIAL_DIVIDER_SIGNED_EN: A=-100 (0x9C) B=7 -> Q=0xF2 (-14), R=0xFE (-2). A=0x80 B=0xFF -> Q=0x80, R=0.
